// File: rtl/branch_resolve_ctrl_if.sv
// Fetch/execute-facing bundle of the branch resolve controller.
// master = fetch/execute side, slave = the controller.
interface branch_resolve_ctrl_if #(
   parameter int WordSize = 32,
   parameter int Depth    = 4
);
   localparam int CW = $clog2(Depth + 1);

   logic                enq_valid;
   logic                enq_ready;
   logic [WordSize-1:0] enq_pc;
   logic [WordSize-1:0] enq_target;
   logic                enq_pred_taken;
   logic                res_valid;
   logic                res_taken;
   logic [WordSize-1:0] res_target;
   logic                redirect;
   logic [WordSize-1:0] redirect_pc;
   logic                flush;
   logic [CW-1:0]       count;
   logic                res_err;
   logic [15:0]         mispredict_cnt;

   modport master (
      output enq_valid, enq_pc, enq_target, enq_pred_taken,
      output res_valid, res_taken, res_target,
      input  enq_ready, redirect, redirect_pc, flush, count, res_err, mispredict_cnt
   );

   modport slave (
      input  enq_valid, enq_pc, enq_target, enq_pred_taken,
      input  res_valid, res_taken, res_target,
      output enq_ready, redirect, redirect_pc, flush, count, res_err, mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order queue of predicted branches; checks oldest-first resolutions, and on a
// mispredict redirects fetch, clears the queue and holds flush for FlushCycles.
module branch_resolve_ctrl #(
   parameter int WordSize    = 32,
   parameter int Depth       = 4,
   parameter int FlushCycles = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   branch_resolve_ctrl_if.slave  io_bus
);
   localparam int PW = $clog2(Depth);
   localparam int CW = $clog2(Depth + 1);
   localparam int FW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_FLUSH} state_t;

   state_t               r_state, w_state_nxt;
   logic [FW-1:0]        r_fcnt, w_fcnt_nxt;

   logic [WordSize-1:0]  r_pc  [Depth];
   logic [WordSize-1:0]  r_tgt [Depth];
   logic                 r_pt  [Depth];
   logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]        r_count;

   logic                 r_redirect;
   logic [WordSize-1:0]  r_redirect_pc;
   logic                 r_res_err;
   logic [15:0]          r_mis_cnt;

   logic                 w_enq_ready, w_res, w_mis, w_pop, w_push;
   logic [WordSize-1:0]  w_hpc, w_htgt;
   logic                 w_hpt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_hpc  = r_pc[r_rd_ptr];
   assign w_htgt = r_tgt[r_rd_ptr];
   assign w_hpt  = r_pt[r_rd_ptr];

   // Ready looks only at registered state; a pop in the same cycle does not free a slot.
   assign w_enq_ready = (r_state == S_RUN) && (r_count < CW'(Depth));
   assign w_res       = (r_state == S_RUN) && io_bus.res_valid && (r_count != '0);
   assign w_mis       = w_res && ((w_hpt != io_bus.res_taken) ||
                                  (io_bus.res_taken && (w_htgt != io_bus.res_target)));
   assign w_pop       = w_res && !w_mis;
   assign w_push      = io_bus.enq_valid && w_enq_ready && !w_mis;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_HOLD;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      case (r_state)
         S_HOLD:  w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_mis) begin
               w_state_nxt = S_FLUSH;
               w_fcnt_nxt  = FW'(FlushCycles - 1);
            end
         end
         S_FLUSH: begin
            if (r_fcnt == '0) w_state_nxt = S_RUN;
            else              w_fcnt_nxt  = r_fcnt - 1'b1;
         end
         default: w_state_nxt = S_HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wr_ptr]  <= io_bus.enq_pc;
         r_tgt[r_wr_ptr] <= io_bus.enq_target;
         r_pt[r_wr_ptr]  <= io_bus.enq_pred_taken;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_res_err     <= 1'b0;
         r_mis_cnt     <= '0;
      end else begin
         r_redirect <= w_mis;
         if (w_mis) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_redirect_pc <= io_bus.res_taken ? io_bus.res_target : w_hpc + WordSize'(4);
            r_mis_cnt     <= r_mis_cnt + 16'd1;
         end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
         end
         if ((r_state == S_RUN) && io_bus.res_valid && (r_count == '0))
            r_res_err <= 1'b1;
      end
   end

   assign io_bus.enq_ready      = w_enq_ready;
   assign io_bus.redirect       = r_redirect;
   assign io_bus.redirect_pc    = r_redirect_pc;
   assign io_bus.flush          = (r_state == S_FLUSH);
   assign io_bus.count          = r_count;
   assign io_bus.res_err        = r_res_err;
   assign io_bus.mispredict_cnt = r_mis_cnt;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_resolve_ctrl;
   localparam int WS = 32;
   localparam int D  = 4;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_ctrl_if #(.WordSize(WS), .Depth(D)) bus ();

   branch_resolve_ctrl #(.WordSize(WS), .Depth(D), .FlushCycles(FC)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .io_bus (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pt;
   } ent_t;

   ent_t        mq[$];
   int          m_phase;   // 0 start-up guard, 1 running, 2 flushing
   int          m_left;
   logic        m_redir;
   logic [31:0] m_rpc;
   logic        m_err;
   logic [15:0] m_mcnt;

   int  n_cmp = 0;
   int  n_err = 0;
   bit  chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_phase = 0;
      m_left  = 0;
      m_redir = 1'b0;
      m_rpc   = '0;
      m_err   = 1'b0;
      m_mcnt  = '0;
   endtask

   task automatic model_edge();
      bit   mis;
      int   sz;
      ent_t h;
      ent_t e;
      mis = 1'b0;
      sz  = mq.size();
      if (!rstn) begin
         model_reset();
         return;
      end
      m_redir = 1'b0;
      if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 2) begin
         m_left--;
         if (m_left == 0) m_phase = 1;
      end else begin
         if (bus.res_valid) begin
            if (sz == 0) begin
               m_err = 1'b1;
            end else begin
               h   = mq[0];
               mis = (h.pt != bus.res_taken) || (bus.res_taken && h.tgt != bus.res_target);
               if (mis) begin
                  mq.delete();
                  m_redir = 1'b1;
                  m_rpc   = bus.res_taken ? bus.res_target : h.pc + 32'd4;
                  m_mcnt  = m_mcnt + 16'd1;
                  m_phase = 2;
                  m_left  = FC;
               end else begin
                  void'(mq.pop_front());
               end
            end
         end
         if (bus.enq_valid && sz < D && !mis) begin
            e.pc  = bus.enq_pc;
            e.tgt = bus.enq_target;
            e.pt  = bus.enq_pred_taken;
            mq.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("enq_ready",      {31'd0, bus.enq_ready}, {31'd0, (m_phase == 1 && mq.size() < D)});
         chk("redirect",       {31'd0, bus.redirect},  {31'd0, m_redir});
         chk("redirect_pc",    bus.redirect_pc,        m_rpc);
         chk("flush",          {31'd0, bus.flush},     {31'd0, (m_phase == 2)});
         chk("count",          32'(bus.count),         32'(mq.size()));
         chk("res_err",        {31'd0, bus.res_err},   {31'd0, m_err});
         chk("mispredict_cnt", {16'd0, bus.mispredict_cnt}, {16'd0, m_mcnt});
      end
   end

   task automatic cyc(input bit ev, input logic [31:0] pc, input logic [31:0] tgt, input bit pt,
                      input bit rv, input bit rt, input logic [31:0] rtg);
      bus.enq_valid      = ev;
      bus.enq_pc         = pc;
      bus.enq_target     = tgt;
      bus.enq_pred_taken = pt;
      bus.res_valid      = rv;
      bus.res_taken      = rt;
      bus.res_target     = rtg;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic enq(input logic [31:0] pc, input logic [31:0] tgt, input bit pt);
      cyc(1, pc, tgt, pt, 0, 0, 0);
   endtask

   task automatic res(input bit rt, input logic [31:0] rtg);
      cyc(0, 0, 0, 0, 1, rt, rtg);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      bus.enq_valid = 1'b0;
      bus.res_valid = 1'b0;
      model_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("rst_flush",    {31'd0, bus.flush},    32'd0);
      chk("rst_count",    32'(bus.count),        32'd0);
      chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
      rstn = 1'b1;
      chk("rel_ready0", {31'd0, bus.enq_ready}, 32'd0);
      idle();
      chk("rel_ready1", {31'd0, bus.enq_ready}, 32'd1);
   endtask

   task automatic expect_redirect(input string name, input logic [31:0] pc_exp);
      chk({name, "_redirect"}, {31'd0, bus.redirect}, 32'd1);
      chk({name, "_rpc"},      bus.redirect_pc,       pc_exp);
      chk({name, "_flush"},    {31'd0, bus.flush},    32'd1);
      chk({name, "_count"},    32'(bus.count),        32'd0);
   endtask

   initial begin
      bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_target = '0; bus.enq_pred_taken = 1'b0;
      bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // 1: reset and start-up guard
      do_reset();

      // 2: fill, stall, correct pop
      for (int i = 0; i < 4; i++) enq(32'h10 + 32'(i) * 4, 32'h100, 1'b1);
      chk("full_count", 32'(bus.count), 32'd4);
      chk("full_ready", {31'd0, bus.enq_ready}, 32'd0);
      enq(32'h50, 32'h100, 1'b1);
      chk("held_count", 32'(bus.count), 32'd4);
      res(1'b1, 32'h100);
      chk("pop_count",    32'(bus.count), 32'd3);
      chk("pop_ready",    {31'd0, bus.enq_ready}, 32'd1);
      chk("pop_redirect", {31'd0, bus.redirect},  32'd0);

      // 3: predicted not-taken, actually taken
      do_reset();
      enq(32'h40, 32'h0, 1'b0);
      res(1'b1, 32'h200);
      expect_redirect("t3", 32'h200);
      chk("t3_mcnt", {16'd0, bus.mispredict_cnt}, 32'd1);
      idle();
      chk("t3_flush2", {31'd0, bus.flush},    32'd1);
      chk("t3_pulse",  {31'd0, bus.redirect}, 32'd0);
      chk("t3_rpc_hold", bus.redirect_pc, 32'h200);
      idle();
      chk("t3_flush_end", {31'd0, bus.flush},     32'd0);
      chk("t3_ready",     {31'd0, bus.enq_ready}, 32'd1);

      // 4: predicted taken, actually not taken
      enq(32'h40, 32'h100, 1'b1);
      res(1'b0, 32'h0);
      expect_redirect("t4", 32'h44);
      chk("t4_mcnt", {16'd0, bus.mispredict_cnt}, 32'd2);
      idle(); idle();

      // 5: fall-through address wraps
      enq(32'hFFFF_FFFC, 32'h100, 1'b1);
      res(1'b0, 32'h0);
      expect_redirect("t5", 32'h0);
      idle(); idle();

      // 6: direction right, target wrong
      enq(32'h40, 32'h100, 1'b1);
      res(1'b1, 32'h180);
      expect_redirect("t6", 32'h180);
      idle(); idle();

      // 7: resolve on empty queue
      res(1'b1, 32'h0);
      chk("t7_err",   {31'd0, bus.res_err}, 32'd1);
      chk("t7_count", 32'(bus.count),       32'd0);
      idle(); idle();
      chk("t7_sticky", {31'd0, bus.res_err}, 32'd1);

      // 8: enqueue alongside a mispredicting resolve is dropped
      do_reset();
      enq(32'h40, 32'h0, 1'b0);
      cyc(1, 32'h80, 32'h300, 1'b1, 1, 1'b1, 32'h200);
      expect_redirect("t8", 32'h200);
      idle(); idle();
      chk("t8_count", 32'(bus.count), 32'd0);

      // 9: reset mid-flush
      enq(32'h40, 32'h0, 1'b0);
      res(1'b1, 32'h200);
      chk("t9_flush_pre", {31'd0, bus.flush}, 32'd1);
      rstn = 1'b0;
      model_reset();
      #1;
      chk("t9_flush", {31'd0, bus.flush},     32'd0);
      chk("t9_count", 32'(bus.count),         32'd0);
      chk("t9_ready", {31'd0, bus.enq_ready}, 32'd0);
      chk("t9_mcnt",  {16'd0, bus.mispredict_cnt}, 32'd0);
      do_reset();

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] pc, tg, rtg;
         bit ev, pt, rv, rt;
         if ($urandom_range(0, 699) == 0) do_reset();
         ev  = ($urandom_range(0, 2) != 0);
         pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'hFFFF), 2'b00};
         tg  = $urandom_range(0, 1) ? 32'h100 : 32'h180;
         pt  = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 2) == 0);
         rt  = ($urandom_range(0, 3) != 0);
         rtg = ($urandom_range(0, 4) == 0) ? 32'h180 : 32'h100;
         cyc(ev, pc, tg, pt, rv, rt, rtg);
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
